// File: rtl/pe_dataflow_sequencer.sv
// Control sequencer for a PE (or a row of PEs on one control bus).
// Accepts a job (dataflow mode + reduction length), steps through
// PRELOAD/CLEAR, COMPUTE, PASS and DRAIN phases, and drives the PE control
// bundle. Every output is decoded from registered state only.
module pe_dataflow_sequencer #(
    parameter int          LEN_W        = 8,
    parameter int          DRAIN_CYCLES = 2,
    parameter logic [15:0] CFG_WS       = 16'h0000,
    parameter logic [15:0] CFG_OS       = 16'h0000,
    parameter logic [15:0] CFG_BYP      = 16'h0000,
    parameter logic [1:0]  MUX_WS       = 2'b00,
    parameter logic [1:0]  MUX_OS       = 2'b00,
    parameter logic [1:0]  MUX_BYP      = 2'b11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] k_len,
    input  logic             abort,
    output logic [15:0]      ctrl_crossbar_flat,
    output logic [1:0]       mux_sel,
    output logic             mac_enable,
    output logic             accum_clear,
    output logic             output_stationary_enable,
    output logic             busy,
    output logic             done,
    output logic [2:0]       phase
);

    // One counter serves both COMPUTE/PASS (length) and DRAIN, so it must
    // hold whichever of the two reload values is wider.
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int CNT_W = (LEN_W > DRN_W) ? LEN_W : DRN_W;

    localparam logic [1:0] MODE_WS = 2'b00;
    localparam logic [1:0] MODE_OS = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRELOAD = 3'd1,
        S_CLEAR   = 3'd2,
        S_COMPUTE = 3'd3,
        S_PASS    = 3'd4,
        S_DRAIN   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [LEN_W-1:0]   len_q, len_d;

    // State, counter and latched job registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic; abort outranks every transition except from IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        len_d   = len_q;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_d = mode;
                        len_d  = k_len;
                        if (k_len == '0) begin
                            state_d = S_DONE;
                        end else if (mode == MODE_WS) begin
                            state_d = S_PRELOAD;
                        end else if (mode == MODE_OS) begin
                            state_d = S_CLEAR;
                        end else begin
                            // Bypass skips setup, so load the counter from the
                            // port since len_q is not yet valid.
                            state_d = S_PASS;
                            cnt_d   = CNT_W'(k_len) - CNT_W'(1);
                        end
                    end
                end
                S_PRELOAD, S_CLEAR: begin
                    state_d = S_COMPUTE;
                    cnt_d   = CNT_W'(len_q) - CNT_W'(1);
                end
                S_COMPUTE: begin
                    if (cnt_q == '0) begin
                        state_d = S_DRAIN;
                        cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_PASS, S_DRAIN: begin
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from registered state and latched mode.
    always_comb begin
        ctrl_crossbar_flat       = CFG_BYP;
        mux_sel                  = MUX_BYP;
        mac_enable               = 1'b0;
        accum_clear              = 1'b0;
        output_stationary_enable = 1'b0;
        done                     = 1'b0;
        busy                     = (state_q != S_IDLE);
        phase                    = state_q;
        unique case (state_q)
            S_PRELOAD: begin
                mac_enable = 1'b1;
            end
            S_CLEAR: begin
                accum_clear = 1'b1;
            end
            S_COMPUTE: begin
                if (mode_q == MODE_WS) begin
                    ctrl_crossbar_flat = CFG_WS;
                    mux_sel            = MUX_WS;
                end else begin
                    ctrl_crossbar_flat       = CFG_OS;
                    mux_sel                  = MUX_OS;
                    mac_enable               = 1'b1;
                    output_stationary_enable = 1'b1;
                end
            end
            S_DRAIN: begin
                // WS keeps its routing while the pipeline flushes; OS results
                // shift out through the bypass path.
                if (mode_q == MODE_WS) begin
                    ctrl_crossbar_flat = CFG_WS;
                    mux_sel            = MUX_WS;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pe_dataflow_sequencer.sv
module tb_pe_dataflow_sequencer;

    localparam logic [15:0] T_CFG_WS  = 16'hA5A5;
    localparam logic [15:0] T_CFG_OS  = 16'h3C3C;
    localparam logic [15:0] T_CFG_BYP = 16'h5555;
    localparam logic [1:0]  T_MUX_WS  = 2'b01;
    localparam logic [1:0]  T_MUX_OS  = 2'b10;
    localparam logic [1:0]  T_MUX_BYP = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  k_len = 8'd0;
    logic        abort = 1'b0;
    logic [15:0] ctrl_crossbar_flat;
    logic [1:0]  mux_sel;
    logic        mac_enable, accum_clear, output_stationary_enable;
    logic        busy, done;
    logic [2:0]  phase;

    int checks = 0;
    int errors = 0;

    pe_dataflow_sequencer #(
        .LEN_W(8), .DRAIN_CYCLES(2),
        .CFG_WS(T_CFG_WS), .CFG_OS(T_CFG_OS), .CFG_BYP(T_CFG_BYP),
        .MUX_WS(T_MUX_WS), .MUX_OS(T_MUX_OS), .MUX_BYP(T_MUX_BYP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .k_len(k_len),
        .abort(abort), .ctrl_crossbar_flat(ctrl_crossbar_flat), .mux_sel(mux_sel),
        .mac_enable(mac_enable), .accum_clear(accum_clear),
        .output_stationary_enable(output_stationary_enable),
        .busy(busy), .done(done), .phase(phase)
    );

    always #5 clk = ~clk;

    // Expected crossbar word for a phase under a job mode.
    function automatic logic [15:0] exp_ctrl(input logic [2:0] ph, input logic [1:0] md);
        if ((ph == 3'd3 || ph == 3'd5) && md == 2'b00) return T_CFG_WS;
        if (ph == 3'd3 && md == 2'b01) return T_CFG_OS;
        return T_CFG_BYP;
    endfunction

    function automatic logic [1:0] exp_mux(input logic [2:0] ph, input logic [1:0] md);
        if ((ph == 3'd3 || ph == 3'd5) && md == 2'b00) return T_MUX_WS;
        if (ph == 3'd3 && md == 2'b01) return T_MUX_OS;
        return T_MUX_BYP;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (phase !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || ctrl_crossbar_flat !== T_CFG_BYP
            || mux_sel !== T_MUX_BYP || mac_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_state phase=%0d busy=%b done=%b ctrl=%h mux=%b mac=%b", phase, busy, done,
                     ctrl_crossbar_flat, mux_sel, mac_enable);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || ctrl_crossbar_flat !== T_CFG_BYP || mac_enable !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d busy=%b done=%b ctrl=%h mac=%b (want 0 0 %h 0)", i, busy,
                         done, ctrl_crossbar_flat, mac_enable, T_CFG_BYP);
            end
        end
    endtask

    task automatic test_ws();
        logic [2:0] seq [8] = '{3'd1, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5, 3'd5, 3'd6};
        mode = 2'b00; k_len = 8'd4; start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            start = 1'b0;
            checks++;
            if (phase !== seq[i] || busy !== 1'b1 || mac_enable !== (seq[i] == 3'd1)
                || done !== (seq[i] == 3'd6) || accum_clear !== 1'b0 || output_stationary_enable !== 1'b0
                || ctrl_crossbar_flat !== exp_ctrl(seq[i], 2'b00) || mux_sel !== exp_mux(seq[i], 2'b00)) begin
                errors++;
                $display("FAIL ws_k4 cyc=%0d phase=%0d want %0d busy=%b mac=%b done=%b ctrl=%h want %h mux=%b",
                         i, phase, seq[i], busy, mac_enable, done, ctrl_crossbar_flat,
                         exp_ctrl(seq[i], 2'b00), mux_sel);
            end
        end
        step();
        checks++;
        if (phase !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ws_end phase=%0d busy=%b done=%b want 0 0 0", phase, busy, done);
        end
    endtask

    task automatic test_os();
        logic [2:0] seq [7] = '{3'd2, 3'd3, 3'd3, 3'd3, 3'd5, 3'd5, 3'd6};
        mode = 2'b01; k_len = 8'd3; start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            start = 1'b0;
            checks++;
            if (phase !== seq[i] || accum_clear !== (seq[i] == 3'd2) || mac_enable !== (seq[i] == 3'd3)
                || output_stationary_enable !== (seq[i] == 3'd3) || done !== (seq[i] == 3'd6)
                || ctrl_crossbar_flat !== exp_ctrl(seq[i], 2'b01) || mux_sel !== exp_mux(seq[i], 2'b01)) begin
                errors++;
                $display("FAIL os_k3 cyc=%0d phase=%0d want %0d clr=%b mac=%b ose=%b done=%b ctrl=%h want %h mux=%b",
                         i, phase, seq[i], accum_clear, mac_enable, output_stationary_enable, done,
                         ctrl_crossbar_flat, exp_ctrl(seq[i], 2'b01), mux_sel);
            end
        end
        step();
    endtask

    task automatic test_zero_and_bypass();
        mode = 2'b01; k_len = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (phase !== 3'd6 || done !== 1'b1 || mac_enable !== 1'b0 || accum_clear !== 1'b0
            || output_stationary_enable !== 1'b0) begin
            errors++;
            $display("FAIL zero_len phase=%0d done=%b mac=%b clr=%b ose=%b want 6 1 0 0 0", phase, done,
                     mac_enable, accum_clear, output_stationary_enable);
        end
        step();
        checks++;
        if (phase !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_end phase=%0d busy=%b want 0 0", phase, busy);
        end
        mode = 2'b11; k_len = 8'd2; start = 1'b1;
        begin
            logic [2:0] seq [3] = '{3'd4, 3'd4, 3'd6};
            for (int i = 0; i < 3; i++) begin
                step();
                start = 1'b0;
                checks++;
                if (phase !== seq[i] || mac_enable !== 1'b0 || busy !== 1'b1 || done !== (seq[i] == 3'd6)
                    || ctrl_crossbar_flat !== T_CFG_BYP || mux_sel !== T_MUX_BYP) begin
                    errors++;
                    $display("FAIL bypass_k2 cyc=%0d phase=%0d want %0d mac=%b busy=%b done=%b ctrl=%h mux=%b",
                             i, phase, seq[i], mac_enable, busy, done, ctrl_crossbar_flat, mux_sel);
                end
            end
        end
        step();
    endtask

    task automatic test_abort();
        mode = 2'b00; k_len = 8'd10; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checks++;
        if (phase !== 3'd3) begin
            errors++;
            $display("FAIL abort_setup phase=%0d want 3", phase);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (phase !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle phase=%0d busy=%b done=%b want 0 0 0", phase, busy, done);
        end
        step();
        mode = 2'b01; k_len = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (phase !== 3'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart phase=%0d busy=%b want 2 1", phase, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        // start and abort together in IDLE: start wins
        mode = 2'b10; k_len = 8'd1; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (phase !== 3'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_beats_abort phase=%0d busy=%b want 4 1", phase, busy);
        end
        step();
        checks++;
        if (phase !== 3'd6 || done !== 1'b1) begin
            errors++;
            $display("FAIL start_beats_abort_done phase=%0d done=%b want 6 1", phase, done);
        end
        step();
    endtask

    task automatic test_back_to_back();
        mode = 2'b10; k_len = 8'd1; start = 1'b1;
        step();
        step();
        // start held high through DONE: only accepted once back in IDLE
        checks++;
        if (phase !== 3'd6) begin
            errors++;
            $display("FAIL b2b_done phase=%0d want 6", phase);
        end
        step();
        checks++;
        if (phase !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap phase=%0d busy=%b want 0 0", phase, busy);
        end
        step();
        start = 1'b0;
        checks++;
        if (phase !== 3'd4) begin
            errors++;
            $display("FAIL b2b_second phase=%0d want 4", phase);
        end
        step();
        step();
    endtask

    task automatic test_busy_start_reset();
        mode = 2'b00; k_len = 8'd2; start = 1'b1;
        step();
        mode = 2'b11; k_len = 8'd0;
        step();
        start = 1'b0;
        checks++;
        if (phase !== 3'd3 || ctrl_crossbar_flat !== T_CFG_WS) begin
            errors++;
            $display("FAIL start_while_busy phase=%0d ctrl=%h want 3 %h", phase, ctrl_crossbar_flat, T_CFG_WS);
        end
        step();
        step();
        checks++;
        if (phase !== 3'd5) begin
            errors++;
            $display("FAIL drain_reach phase=%0d want 5", phase);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (phase !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || mac_enable !== 1'b0
            || ctrl_crossbar_flat !== T_CFG_BYP || mux_sel !== T_MUX_BYP) begin
            errors++;
            $display("FAIL async_reset phase=%0d busy=%b done=%b mac=%b ctrl=%h mux=%b", phase, busy, done,
                     mac_enable, ctrl_crossbar_flat, mux_sel);
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (phase !== 3'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset phase=%0d done=%b want 0 0", phase, done);
        end
    endtask

    task automatic test_wrap();
        int busy_cyc = 0;
        int guard = 0;
        logic saw_done = 1'b0;
        mode = 2'b00; k_len = 8'd255; start = 1'b1;
        step();
        start = 1'b0;
        while (busy === 1'b1 && guard < 400) begin
            busy_cyc++;
            if (done === 1'b1) saw_done = 1'b1;
            step();
            guard++;
        end
        checks++;
        if (busy_cyc != 259 || saw_done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_k255 busy_cycles=%0d done_seen=%b want 259 1", busy_cyc, saw_done);
        end
    endtask

    initial begin
        test_reset();
        test_ws();
        test_os();
        test_zero_and_bypass();
        test_abort();
        test_back_to_back();
        test_busy_start_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
